// File: rtl/fir_pkg.sv
// Shared state type, default geometry and counter-width helper for the FIR sequencing controller.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fir_state_t;

    localparam int FIR_TAPS_DEF     = 64;
    localparam int FIR_ADDR_W_DEF   = 6;
    localparam int FIR_PIPE_LAT_DEF = 2;
    localparam int SAMPLE_CNT_W     = 16;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tap_counter.sv
// Up-counter from 0 to MAX-1 that parks at its terminal value until cleared.
module tap_counter #(
    parameter int MAX = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_enable,
    output logic [W-1:0] o_count,
    output logic         o_terminal
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] r_count;

    // Parking at LAST is what keeps the tap address from ever wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == LAST);
    assign o_count    = r_count;

endmodule

// File: rtl/fir_controller.sv
// Sequencer for a multi-cycle FIR datapath: accepts one sample, walks TAPS addresses, drains, holds the result.
// Optional macro FIR_CTRL_PERF_EN adds a saturating sample_count of completed output handshakes.
module fir_controller
    import fir_pkg::*;
#(
    parameter int TAPS     = FIR_TAPS_DEF,
    parameter int ADDR_W   = FIR_ADDR_W_DEF,
    parameter int PIPE_LAT = FIR_PIPE_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              shift,
    output logic              flush,
    output logic [ADDR_W-1:0] address
`ifdef FIR_CTRL_PERF_EN
    ,
    output logic [SAMPLE_CNT_W-1:0] sample_count
`endif
);

    localparam int DRAIN_W = cnt_width(PIPE_LAT);

    fir_state_t         r_state;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_out_hs;
    logic               w_in_mac;
    logic               w_in_drain;
    logic               w_mac_last;
    logic               w_drain_last;
    logic               w_mac_clear;
    logic               w_drain_clear;
    logic [ADDR_W-1:0]  w_mac_count;
    logic [DRAIN_W-1:0] w_drain_count_unused;

    // rst gates in_ready so nothing is accepted while reset is held.
    assign in_ready   = (r_state == IDLE) && !rst;
    assign w_accept   = in_ready && in_valid;
    assign shift      = w_accept;
    assign flush      = w_accept;
    assign out_valid  = r_out_valid;
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_in_mac   = (r_state == MAC);
    assign w_in_drain = (r_state == DRAIN);

    assign w_mac_clear   = w_accept || w_out_hs;
    assign w_drain_clear = w_in_mac && w_mac_last;

    tap_counter #(
        .MAX (TAPS),
        .W   (ADDR_W)
    ) u_mac_count (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_mac_clear),
        .i_enable   (w_in_mac),
        .o_count    (w_mac_count),
        .o_terminal (w_mac_last)
    );

    tap_counter #(
        .MAX (PIPE_LAT),
        .W   (DRAIN_W)
    ) u_drain_count (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_drain_clear),
        .i_enable   (w_in_drain),
        .o_count    (w_drain_count_unused),
        .o_terminal (w_drain_last)
    );

    // The MAC counter parks at TAPS-1 through DRAIN and HOLD, so it doubles as the address.
    assign address = w_mac_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    if (w_mac_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drain_last) begin
                        r_state     <= HOLD;
                        r_out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef FIR_CTRL_PERF_EN
    logic [SAMPLE_CNT_W-1:0] r_sample_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_count <= '0;
        end else if (w_out_hs && (r_sample_count != '1)) begin
            r_sample_count <= r_sample_count + 1'b1;
        end
    end

    assign sample_count = r_sample_count;
`endif

endmodule

// File: tb/tb_fir_controller.sv
// Randomised bench for fir_controller: a timing model predicts every cycle, a scoreboard checks result latency.
module tb_fir_controller;

    localparam int TAPS   = 64;
    localparam int ADDR_W = 6;
    localparam int PL     = 2;
    localparam int LAT    = 1 + TAPS + PL;

    localparam int S_TAPS   = 4;
    localparam int S_ADDR_W = 2;
    localparam int S_PL     = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, shift, flush;
    logic [ADDR_W-1:0] address;

    logic s_in_valid = 1'b0;
    logic s_out_ready = 1'b0;
    logic s_in_ready, s_out_valid, s_shift, s_flush;
    logic [S_ADDR_W-1:0] s_address;

`ifdef FIR_CTRL_PERF_EN
    logic [15:0] sample_count;
    logic [15:0] s_sample_count;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit m_busy = 0;
    int m_start = 0;
    int m_frames = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_controller #(.TAPS(TAPS), .ADDR_W(ADDR_W), .PIPE_LAT(PL)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .shift     (shift),
        .flush     (flush),
        .address   (address)
`ifdef FIR_CTRL_PERF_EN
        ,
        .sample_count (sample_count)
`endif
    );

    fir_controller #(.TAPS(S_TAPS), .ADDR_W(S_ADDR_W), .PIPE_LAT(S_PL)) u_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .out_ready (s_out_ready),
        .out_valid (s_out_valid),
        .shift     (s_shift),
        .flush     (s_flush),
        .address   (s_address)
`ifdef FIR_CTRL_PERF_EN
        ,
        .sample_count (s_sample_count)
`endif
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Timing model: frame position is plain arithmetic on the cycle of acceptance.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_in_ready", in_ready, 0);
                chk("rst_address", address, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_shift", shift, 0);
                chk("rst_flush", flush, 0);
                m_busy = 0;
                m_frames = 0;
                exp_q.delete();
            end else if (!m_busy) begin
                chk("idle_in_ready", in_ready, 1);
                chk("idle_address", address, 0);
                chk("idle_out_valid", out_valid, 0);
                chk("idle_shift", shift, in_valid);
                chk("idle_flush", flush, in_valid);
                if (in_valid) begin
                    m_busy = 1;
                    m_start = cyc;
                    exp_q.push_back(cyc + LAT);
                    $display("accept sample at cycle %0d, result due at cycle %0d", cyc, cyc + LAT);
                end
            end else begin
                d = cyc - m_start;
                chk("busy_in_ready", in_ready, 0);
                chk("busy_shift", shift, 0);
                chk("busy_flush", flush, 0);
                if (d <= TAPS) begin
                    chk("mac_address", address, d - 1);
                    chk("mac_out_valid", out_valid, 0);
                end else if (d <= TAPS + PL) begin
                    chk("drain_address", address, TAPS - 1);
                    chk("drain_out_valid", out_valid, 0);
                end else begin
                    chk("hold_address", address, TAPS - 1);
                    chk("hold_out_valid", out_valid, 1);
                    if (out_ready) begin
                        m_busy = 0;
                        m_frames++;
                        $display("result taken at cycle %0d (frame %0d since reset)", cyc, m_frames);
                    end
                end
            end
        end
    end

    // Scoreboard monitor: each rising out_valid consumes one predicted result.
    initial begin
        logic prev_ov;
        int e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_out_valid at cycle %0d: got out_valid=1, expected no pending sample", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_out_valid_cycle", cyc, e);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (in_ready && !rst) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_idle_timeout at cycle %0d: got in_ready=%0d, expected 1 within %0d cycles", cyc, in_ready, lim);
    endtask

    task automatic wait_out_valid(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_out_valid_timeout at cycle %0d: got out_valid=0, expected 1 within %0d cycles", cyc, lim);
    endtask

    task automatic send_one();
        @(posedge clk);
        #1 in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        int n;
        bit found;
        int exp_a;
        int exp_v;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Sample presented in the very first cycle after reset release.
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle(200);

        // Backpressure: hold the result for 10 extra cycles.
        out_ready = 1'b0;
        send_one();
        wait_out_valid(200);
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle(20);

        // in_valid held high: exactly one accept per frame.
        @(posedge clk);
        #1 in_valid = 1'b1;
        n = 0;
        repeat (3 * (LAT + 1)) begin
            @(negedge clk);
            if (shift) n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("busy_shift_count", n, 3);
        wait_idle(200);

        // Reset pulsed in the middle of the MAC walk.
        send_one();
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (address == 30) found = 1;
        end
        chk("midrst_reached_addr30", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_address", address, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(negedge clk);
        send_one();
        wait_idle(200);

        // Random traffic.
        repeat (800) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 7) == 0);
            out_ready = $urandom_range(0, 1) == 1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle(200);
        chk("sb_queue_drained", exp_q.size(), 0);

`ifdef FIR_CTRL_PERF_EN
        chk("perf_sample_count", sample_count, m_frames);
`endif

        // Small geometry: TAPS=4, PIPE_LAT=1 gives out_valid 6 cycles after the handshake.
        @(posedge clk);
        #1 s_in_valid = 1'b1;
        s_out_ready = 1'b1;
        @(negedge clk);
        chk("small_shift", s_shift, 1);
        chk("small_flush", s_flush, 1);
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        for (int k = 1; k <= S_TAPS + S_PL + 2; k++) begin
            @(negedge clk);
            if (k <= S_TAPS) exp_a = k - 1;
            else if (k <= S_TAPS + S_PL + 1) exp_a = S_TAPS - 1;
            else exp_a = 0;
            exp_v = (k == S_TAPS + S_PL + 1) ? 1 : 0;
            chk("small_address", s_address, exp_a);
            chk("small_out_valid", s_out_valid, exp_v);
            chk("small_in_ready", s_in_ready, (k > S_TAPS + S_PL + 1) ? 1 : 0);
            $display("small frame cycle %0d: address=%0d out_valid=%0d", k, s_address, s_out_valid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog at cycle %0d: got no completion, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
